// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS decode encodings and the registered control bundle type.
//   opcode/funct/rt/rs field values, exception codes, ALU/MD/DM encodings,
//   ctrl_bundle_t and its idle (no-op) value.
package mips_ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                         OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                         OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08,
                         OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0A, OP_SLTIU = 6'h0B,
                         OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E,
                         OP_LUI     = 6'h0F, OP_COP0   = 6'h10, OP_LB    = 6'h20,
                         OP_LH      = 6'h21, OP_LW     = 6'h23, OP_LBU   = 6'h24,
                         OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29,
                         OP_SW      = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] F_SLL   = 6'h00, F_SRL   = 6'h02, F_SRA   = 6'h03,
                         F_SLLV  = 6'h04, F_SRLV  = 6'h06, F_SRAV  = 6'h07,
                         F_JR    = 6'h08, F_JALR  = 6'h09, F_SYSC  = 6'h0C,
                         F_BREAK = 6'h0D, F_MFHI  = 6'h10, F_MTHI  = 6'h11,
                         F_MFLO  = 6'h12, F_MTLO  = 6'h13, F_MULT  = 6'h18,
                         F_MULTU = 6'h19, F_DIV   = 6'h1A, F_DIVU  = 6'h1B,
                         F_ADD   = 6'h20, F_ADDU  = 6'h21, F_SUB   = 6'h22,
                         F_SUBU  = 6'h23, F_AND   = 6'h24, F_OR    = 6'h25,
                         F_XOR   = 6'h26, F_NOR   = 6'h27, F_SLT   = 6'h2A,
                         F_SLTU  = 6'h2B, F_ERET  = 6'h18;

  // REGIMM rt and COP0 rs selectors
  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01, RT_BLTZAL = 5'h10,
                         RT_BGEZAL = 5'h11;
  localparam logic [4:0] RS_MF = 5'h00, RS_MT = 5'h04, RS_CO = 5'h10;

  // Exception codes
  localparam logic [4:0] EXC_INT = 5'd0, EXC_ADEL = 5'd4, EXC_SYS = 5'd8,
                         EXC_BP  = 5'd9, EXC_RI   = 5'd10;

  // ALU opcodes
  localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2,
                         ALU_OR  = 4'd3,  ALU_XOR  = 4'd4,  ALU_NOR  = 4'd5,
                         ALU_SLT = 4'd6,  ALU_SLTU = 4'd7,  ALU_SLL  = 4'd8,
                         ALU_SRL = 4'd9,  ALU_SRA  = 4'd10, ALU_ADDU = 4'd11,
                         ALU_SUBU = 4'd12, ALU_LUI = 4'd13, ALU_NONE = 4'hF;

  // Multiply/divide opcodes
  localparam logic [1:0] MD_MULTU = 2'd0, MD_MULT = 2'd1, MD_DIVU = 2'd2, MD_DIV = 2'd3;

  // Data-memory access size
  localparam logic [2:0] DM_SB = 3'd0, DM_SH = 3'd1, DM_SW = 3'd2, DM_LBU = 3'd3,
                         DM_LB = 3'd4, DM_LHU = 3'd5, DM_LH = 3'd6, DM_OTHER = 3'd7;

  typedef struct packed {
    logic       rf_wr;
    logic       dm_wr;
    logic       dm_rd;
    logic       hl_wr;
    logic       cp0_wr;
    logic       cp0_rd;
    logic       eret;
    logic       md_start;
    logic       exc;
    logic [4:0] exc_code;
    logic [2:0] dm_sel;
    logic [3:0] alu1_op;
    logic [1:0] alu2_op;
  } ctrl_bundle_t;

  localparam ctrl_bundle_t CTRL_IDLE = '{dm_sel: DM_OTHER, alu1_op: ALU_NONE, default: '0};

endpackage

// File: rtl/dec_comb.sv
// Combinational MIPS-I instruction decoder.
//   instr        : raw instruction word
//   ctrl         : control bundle (RI/Bp/Sys exceptions already folded in)
//   is_branch    : branch or jump (the next instruction is a delay slot)
//   is_hl_access : touches HI/LO or starts the MD unit
module dec_comb
  import mips_ctrl_pkg::*;
(
  input  logic [31:0]  instr,
  output ctrl_bundle_t ctrl,
  output logic         is_branch,
  output logic         is_hl_access
);

  logic [5:0] op, funct;
  logic [4:0] rs, rt;
  logic [3:0] alu_rf;
  logic       ri, brk, sys;
  logic       unused_bits;

  assign op     = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign funct  = instr[5:0];
  assign unused_bits = ^instr[15:6];

  always_comb begin
    ctrl         = CTRL_IDLE;
    is_branch    = 1'b0;
    is_hl_access = 1'b0;
    alu_rf       = ALU_NONE;   // ALU op whose result is written to the RF
    ri           = 1'b0;
    brk          = 1'b0;
    sys          = 1'b0;
    case (op)
      OP_SPECIAL: begin
        case (funct)
          F_SLL, F_SLLV: alu_rf = ALU_SLL;
          F_SRL, F_SRLV: alu_rf = ALU_SRL;
          F_SRA, F_SRAV: alu_rf = ALU_SRA;
          F_ADD:         alu_rf = ALU_ADD;
          F_ADDU:        alu_rf = ALU_ADDU;
          F_SUB:         alu_rf = ALU_SUB;
          F_SUBU:        alu_rf = ALU_SUBU;
          F_AND:         alu_rf = ALU_AND;
          F_OR:          alu_rf = ALU_OR;
          F_XOR:         alu_rf = ALU_XOR;
          F_NOR:         alu_rf = ALU_NOR;
          F_SLT:         alu_rf = ALU_SLT;
          F_SLTU:        alu_rf = ALU_SLTU;
          F_JR:          is_branch = 1'b1;
          F_JALR:        begin is_branch = 1'b1; ctrl.rf_wr = 1'b1; end
          F_SYSC:        sys = 1'b1;
          F_BREAK:       brk = 1'b1;
          F_MFHI, F_MFLO: begin ctrl.rf_wr = 1'b1; is_hl_access = 1'b1; end
          F_MTHI, F_MTLO: begin ctrl.hl_wr = 1'b1; is_hl_access = 1'b1; end
          F_MULT:  begin ctrl.md_start = 1'b1; ctrl.alu2_op = MD_MULT;  is_hl_access = 1'b1; end
          F_MULTU: begin ctrl.md_start = 1'b1; ctrl.alu2_op = MD_MULTU; is_hl_access = 1'b1; end
          F_DIV:   begin ctrl.md_start = 1'b1; ctrl.alu2_op = MD_DIV;   is_hl_access = 1'b1; end
          F_DIVU:  begin ctrl.md_start = 1'b1; ctrl.alu2_op = MD_DIVU;  is_hl_access = 1'b1; end
          default: ri = 1'b1;
        endcase
      end
      OP_REGIMM: begin
        case (rt)
          RT_BLTZ, RT_BGEZ:     is_branch = 1'b1;
          RT_BLTZAL, RT_BGEZAL: begin is_branch = 1'b1; ctrl.rf_wr = 1'b1; end
          default:              ri = 1'b1;
        endcase
      end
      OP_J:             is_branch = 1'b1;
      OP_JAL:           begin is_branch = 1'b1; ctrl.rf_wr = 1'b1; end
      OP_BEQ, OP_BNE:   begin is_branch = 1'b1; ctrl.alu1_op = ALU_SUB; end
      OP_BLEZ, OP_BGTZ: is_branch = 1'b1;
      OP_ADDI:  alu_rf = ALU_ADD;
      OP_ADDIU: alu_rf = ALU_ADDU;
      OP_SLTI:  alu_rf = ALU_SLT;
      OP_SLTIU: alu_rf = ALU_SLTU;
      OP_ANDI:  alu_rf = ALU_AND;
      OP_ORI:   alu_rf = ALU_OR;
      OP_XORI:  alu_rf = ALU_XOR;
      OP_LUI:   alu_rf = ALU_LUI;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctrl.rf_wr   = 1'b1;
        ctrl.dm_rd   = 1'b1;
        ctrl.alu1_op = ALU_ADD;
        case (op)
          OP_LB:   ctrl.dm_sel = DM_LB;
          OP_LH:   ctrl.dm_sel = DM_LH;
          OP_LBU:  ctrl.dm_sel = DM_LBU;
          OP_LHU:  ctrl.dm_sel = DM_LHU;
          default: ctrl.dm_sel = DM_OTHER;
        endcase
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.dm_wr   = 1'b1;
        ctrl.alu1_op = ALU_ADD;
        case (op)
          OP_SB:   ctrl.dm_sel = DM_SB;
          OP_SH:   ctrl.dm_sel = DM_SH;
          default: ctrl.dm_sel = DM_SW;
        endcase
      end
      OP_COP0: begin
        if (rs == RS_MF)                           begin ctrl.cp0_rd = 1'b1; ctrl.rf_wr = 1'b1; end
        else if (rs == RS_MT)                      ctrl.cp0_wr = 1'b1;
        else if (rs == RS_CO && funct == F_ERET)   ctrl.eret = 1'b1;
        else                                       ri = 1'b1;
      end
      default: ri = 1'b1;
    endcase

    if (alu_rf != ALU_NONE) begin
      ctrl.rf_wr   = 1'b1;
      ctrl.alu1_op = alu_rf;
    end

    // An excepting instruction carries no side effects
    if (ri || brk || sys) begin
      ctrl          = CTRL_IDLE;
      ctrl.exc      = 1'b1;
      ctrl.exc_code = ri ? EXC_RI : (brk ? EXC_BP : EXC_SYS);
      is_branch     = 1'b0;
      is_hl_access  = 1'b0;
    end
  end

endmodule

// File: rtl/dec_issue_ctrl.sv
// Registered decode/issue control stage between IF/ID and EX.
//   in_valid/in_ready/instr/in_adel : upstream instruction handshake
//   int_req/int_en                  : interrupt requests and global enable
//   flush                           : drop held bundle and current input
//   out_valid/out_ready + bundle    : one-entry registered output stage
//   md_busy                         : multiply/divide unit still in flight
module dec_issue_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32,
  parameter int unsigned N_INT   = 6,
  parameter logic [N_INT-1:0] INT_MASK = {N_INT{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic             in_adel,
  input  logic [N_INT-1:0] int_req,
  input  logic             int_en,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             rf_wr,
  output logic             dm_wr,
  output logic             dm_rd,
  output logic             hl_wr,
  output logic             cp0_wr,
  output logic             cp0_rd,
  output logic             eret,
  output logic [2:0]       dm_sel,
  output logic [3:0]       alu1_op,
  output logic [1:0]       alu2_op,
  output logic             md_start,
  output logic             is_bd,
  output logic             exc,
  output logic [4:0]       exc_code,
  output logic             md_busy
);

  localparam int unsigned CNT_W = $clog2(DIV_LAT + 1);

  ctrl_bundle_t     dec, issue, bundle_q;
  logic             is_branch, is_hl_access;
  logic             out_valid_q, bd_q, is_bd_q;
  logic [CNT_W-1:0] md_cnt;
  logic             hl_stall, int_take, accept;

  dec_comb u_dec (
    .instr        (instr),
    .ctrl         (dec),
    .is_branch    (is_branch),
    .is_hl_access (is_hl_access)
  );

  assign md_busy  = (md_cnt != '0);
  assign hl_stall = is_hl_access & md_busy;
  assign int_take = (|(int_req & INT_MASK)) & int_en;
  assign in_ready = rst & ~flush & (~out_valid_q | out_ready) & ~hl_stall;
  assign accept   = in_valid & in_ready;

  // Interrupt outranks fetch error, which outranks decoder exceptions
  always_comb begin
    issue = dec;
    if (int_take) begin
      issue          = CTRL_IDLE;
      issue.exc      = 1'b1;
      issue.exc_code = EXC_INT;
    end else if (in_adel) begin
      issue          = CTRL_IDLE;
      issue.exc      = 1'b1;
      issue.exc_code = EXC_ADEL;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      bundle_q    <= CTRL_IDLE;
      is_bd_q     <= 1'b0;
      bd_q        <= 1'b0;
      md_cnt      <= '0;
    end else begin
      if (flush)          out_valid_q <= 1'b0;
      else if (accept)    out_valid_q <= 1'b1;
      else if (out_ready) out_valid_q <= 1'b0;

      if (accept) begin
        bundle_q <= issue;
        is_bd_q  <= bd_q;
      end

      if (flush)       bd_q <= 1'b0;
      else if (accept) bd_q <= is_branch;

      // Only a bundle that actually starts the MD unit occupies it
      if (accept && issue.md_start)
        md_cnt <= issue.alu2_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
      else if (md_busy)
        md_cnt <= md_cnt - CNT_W'(1);
    end
  end

  assign out_valid = out_valid_q;
  assign is_bd     = is_bd_q;
  assign rf_wr     = bundle_q.rf_wr;
  assign dm_wr     = bundle_q.dm_wr;
  assign dm_rd     = bundle_q.dm_rd;
  assign hl_wr     = bundle_q.hl_wr;
  assign cp0_wr    = bundle_q.cp0_wr;
  assign cp0_rd    = bundle_q.cp0_rd;
  assign eret      = bundle_q.eret;
  assign dm_sel    = bundle_q.dm_sel;
  assign alu1_op   = bundle_q.alu1_op;
  assign alu2_op   = bundle_q.alu2_op;
  assign md_start  = bundle_q.md_start;
  assign exc       = bundle_q.exc;
  assign exc_code  = bundle_q.exc_code;

endmodule

// File: tb/tb_dec_issue_ctrl.sv
// Self-checking bench for dec_issue_ctrl: a table of single-instruction
// vectors followed by hand-written multi-cycle sequences.
module tb_dec_issue_ctrl;

  logic        clk, rst, in_valid, in_ready, in_adel, int_en, flush;
  logic        out_valid, out_ready;
  logic [31:0] instr;
  logic [5:0]  int_req;
  logic        rf_wr, dm_wr, dm_rd, hl_wr, cp0_wr, cp0_rd, eret, md_start, is_bd, exc, md_busy;
  logic [2:0]  dm_sel;
  logic [3:0]  alu1_op;
  logic [1:0]  alu2_op;
  logic [4:0]  exc_code;

  int n_chk = 0;
  int n_fail = 0;
  int n;

  dec_issue_ctrl #(.MUL_LAT(4), .DIV_LAT(32), .N_INT(6), .INT_MASK(6'b111111)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .in_adel(in_adel), .int_req(int_req), .int_en(int_en), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .rf_wr(rf_wr), .dm_wr(dm_wr),
    .dm_rd(dm_rd), .hl_wr(hl_wr), .cp0_wr(cp0_wr), .cp0_rd(cp0_rd), .eret(eret),
    .dm_sel(dm_sel), .alu1_op(alu1_op), .alu2_op(alu2_op), .md_start(md_start),
    .is_bd(is_bd), .exc(exc), .exc_code(exc_code), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    logic        adel;
    logic [5:0]  irq;
    logic        ien;
    logic [8:0]  en;    // rf_wr dm_wr dm_rd hl_wr cp0_wr cp0_rd eret md_start exc
    logic [4:0]  code;
    logic [2:0]  sel;
    logic [3:0]  alu1;
    logic [1:0]  alu2;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs[NV];

  localparam logic [31:0] I_ADDU = 32'h00221821, I_SW   = 32'hAC230008,
                          I_MULT = 32'h00220018, I_DIV  = 32'h0022001A,
                          I_MFLO = 32'h00001812, I_MFHI = 32'h00001810,
                          I_BEQ  = 32'h10220003, I_ORI  = 32'h34230055;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic adel, input logic [5:0] irq, input logic ien);
    instr   = i;
    in_adel = adel;
    int_req = irq;
    int_en  = ien;
  endtask

  function automatic logic [22:0] obs();
    return {rf_wr, dm_wr, dm_rd, hl_wr, cp0_wr, cp0_rd, eret, md_start, exc,
            exc_code, dm_sel, alu1_op, alu2_op};
  endfunction

  initial begin
    //          instr         adel  irq        ien   en            code   sel   alu1   alu2
    vecs[0]  = '{32'h00221821, 1'b0, 6'b000000, 1'b0, 9'b100000000, 5'd0,  3'd7, 4'hB, 2'd0}; // ADDU
    vecs[1]  = '{32'h8C230004, 1'b0, 6'b000000, 1'b0, 9'b101000000, 5'd0,  3'd7, 4'h0, 2'd0}; // LW
    vecs[2]  = '{32'hAC230008, 1'b0, 6'b000000, 1'b0, 9'b010000000, 5'd0,  3'd2, 4'h0, 2'd0}; // SW
    vecs[3]  = '{32'hA0230001, 1'b0, 6'b000000, 1'b0, 9'b010000000, 5'd0,  3'd0, 4'h0, 2'd0}; // SB
    vecs[4]  = '{32'hA4230002, 1'b0, 6'b000000, 1'b0, 9'b010000000, 5'd0,  3'd1, 4'h0, 2'd0}; // SH
    vecs[5]  = '{32'h90230000, 1'b0, 6'b000000, 1'b0, 9'b101000000, 5'd0,  3'd3, 4'h0, 2'd0}; // LBU
    vecs[6]  = '{32'h80230000, 1'b0, 6'b000000, 1'b0, 9'b101000000, 5'd0,  3'd4, 4'h0, 2'd0}; // LB
    vecs[7]  = '{32'h94230002, 1'b0, 6'b000000, 1'b0, 9'b101000000, 5'd0,  3'd5, 4'h0, 2'd0}; // LHU
    vecs[8]  = '{32'h84230002, 1'b0, 6'b000000, 1'b0, 9'b101000000, 5'd0,  3'd6, 4'h0, 2'd0}; // LH
    vecs[9]  = '{32'h34230055, 1'b0, 6'b000000, 1'b0, 9'b100000000, 5'd0,  3'd7, 4'h3, 2'd0}; // ORI
    vecs[10] = '{32'h00221823, 1'b0, 6'b000000, 1'b0, 9'b100000000, 5'd0,  3'd7, 4'hC, 2'd0}; // SUBU
    vecs[11] = '{32'h00021880, 1'b0, 6'b000000, 1'b0, 9'b100000000, 5'd0,  3'd7, 4'h8, 2'd0}; // SLL
    vecs[12] = '{32'h00200011, 1'b0, 6'b000000, 1'b0, 9'b000100000, 5'd0,  3'd7, 4'hF, 2'd0}; // MTHI
    vecs[13] = '{32'h40036000, 1'b0, 6'b000000, 1'b0, 9'b100001000, 5'd0,  3'd7, 4'hF, 2'd0}; // MFC0
    vecs[14] = '{32'h40836000, 1'b0, 6'b000000, 1'b0, 9'b000010000, 5'd0,  3'd7, 4'hF, 2'd0}; // MTC0
    vecs[15] = '{32'h42000018, 1'b0, 6'b000000, 1'b0, 9'b000000100, 5'd0,  3'd7, 4'hF, 2'd0}; // ERET
    vecs[16] = '{32'h74000000, 1'b0, 6'b000000, 1'b0, 9'b000000001, 5'd10, 3'd7, 4'hF, 2'd0}; // RI
    vecs[17] = '{32'h0000000C, 1'b0, 6'b000000, 1'b0, 9'b000000001, 5'd8,  3'd7, 4'hF, 2'd0}; // SYSCALL
    vecs[18] = '{32'h0000000D, 1'b0, 6'b000000, 1'b0, 9'b000000001, 5'd9,  3'd7, 4'hF, 2'd0}; // BREAK
    vecs[19] = '{32'h0000000D, 1'b1, 6'b000000, 1'b0, 9'b000000001, 5'd4,  3'd7, 4'hF, 2'd0}; // BREAK+AdEL
    vecs[20] = '{32'hAC230008, 1'b0, 6'b000100, 1'b1, 9'b000000001, 5'd0,  3'd7, 4'hF, 2'd0}; // SW+Int
    vecs[21] = '{32'h00221821, 1'b0, 6'b000100, 1'b0, 9'b100000000, 5'd0,  3'd7, 4'hB, 2'd0}; // ADDU, IE off
    vecs[22] = '{32'h0C000010, 1'b0, 6'b000000, 1'b0, 9'b100000000, 5'd0,  3'd7, 4'hF, 2'd0}; // JAL

    // Reset held for three cycles with a valid instruction offered
    rst = 1'b0; in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    drive(I_ADDU, 1'b0, 6'd0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_alu1_op", alu1_op, 4'hF);
      chk("rst_dm_sel", dm_sel, 3'd7);
      chk("rst_md_busy", md_busy, 0);
    end
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);

    // Back-to-back single-instruction vectors, one accepted per cycle
    for (int k = 0; k < NV; k++) begin
      drive(vecs[k].instr, vecs[k].adel, vecs[k].irq, vecs[k].ien);
      in_valid = 1'b1;
      #1 chk($sformatf("vec%0d_in_ready", k), in_ready, 1);
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", k), out_valid, 1);
      chk($sformatf("vec%0d_bundle", k), 32'(obs()),
          32'({vecs[k].en, vecs[k].code, vecs[k].sel, vecs[k].alu1, vecs[k].alu2}));
    end
    in_valid = 1'b0;
    drive(I_ADDU, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    chk("drain_out_valid", out_valid, 0);

    // MULT then MFLO: MFLO waits out the multiply latency
    drive(I_MULT, 1'b0, 6'd0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("mult_md_start", md_start, 1);
    chk("mult_alu2_op", alu2_op, 2'd1);
    chk("mult_md_busy", md_busy, 1);
    drive(I_MFLO, 1'b0, 6'd0, 1'b0);
    #1 n = 0;
    while (!in_ready && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("mflo_stall_cycles", 32'(n), 4);
    chk("mflo_md_idle", md_busy, 0);
    @(negedge clk);
    chk("mflo_out_valid", out_valid, 1);
    chk("mflo_bundle", 32'(obs()), 32'({9'b100000000, 5'd0, 3'd7, 4'hF, 2'd0}));
    in_valid = 1'b0;

    // DIV occupies the MD unit for the divide latency
    drive(I_DIV, 1'b0, 6'd0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("div_alu2_op", alu2_op, 2'd3);
    n = 0;
    while (md_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("div_busy_cycles", 32'(n), 32);

    // Flush kills the bundle but not the in-flight multiply
    drive(I_MULT, 1'b0, 6'd0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_md_busy", md_busy, 1);
    n = 1;
    while (md_busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("flush_mult_cycles", 32'(n), 4);

    // Interrupt during an HI/LO stall: stall first, interrupt on accept
    drive(I_MULT, 1'b0, 6'd0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    drive(I_MFHI, 1'b0, 6'b000100, 1'b1);
    #1 n = 0;
    while (!in_ready && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk("int_stall_cycles", 32'(n), 4);
    @(negedge clk);
    chk("int_mfhi_bundle", 32'(obs()), 32'({9'b000000001, 5'd0, 3'd7, 4'hF, 2'd0}));
    in_valid = 1'b0;
    drive(I_ADDU, 1'b0, 6'd0, 1'b0);

    // Backpressure: SW held for five cycles, pending ADDU waits
    drive(I_SW, 1'b0, 6'd0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    drive(I_ADDU, 1'b0, 6'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp%0d_out_valid", i), out_valid, 1);
      chk($sformatf("bp%0d_bundle", i), 32'(obs()), 32'({9'b010000000, 5'd0, 3'd2, 4'h0, 2'd0}));
      chk($sformatf("bp%0d_in_ready", i), in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_in_ready", in_ready, 1);
    @(negedge clk);
    chk("bp_addu_bundle", 32'(obs()), 32'({9'b100000000, 5'd0, 3'd7, 4'hB, 2'd0}));

    // Branch delay slot tracking
    drive(I_BEQ, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    chk("beq_is_bd", is_bd, 0);
    drive(I_ORI, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    chk("ori_is_bd", is_bd, 1);
    chk("ori_alu1_op", alu1_op, 4'h3);
    drive(I_ADDU, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    chk("after_slot_is_bd", is_bd, 0);

    // Flush between branch and its slot clears the delay-slot flag
    drive(I_BEQ, 1'b0, 6'd0, 1'b0);
    @(negedge clk);
    drive(I_ORI, 1'b0, 6'd0, 1'b0);
    flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    @(negedge clk);
    chk("flush_drop_valid", out_valid, 0);
    flush = 1'b0;
    @(negedge clk);
    chk("flushed_ori_valid", out_valid, 1);
    chk("flushed_ori_is_bd", is_bd, 0);
    in_valid = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
